raytracing_job_scheduler: RTL

//  Initiator side of the worker activate/busy/buffer interface. Sweeps a H_RES x V_RES frame in

---
 rtl/raytracing_job_scheduler.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/raytracing_job_scheduler.sv
// Batch scheduler: launches all workers on a strip of pixels, waits for completion, then drains
// their colour buffers to the framebuffer in screen order. SCHED_PERF_COUNTER_EN adds frame_cycles.
module raytracing_job_scheduler #(
    parameter int N_WORKERS        = 4,
    parameter int JOBS_SUBDIVISION = 16,
    parameter int H_RES            = 640,
    parameter int V_RES            = 480,
    parameter int COLOR_B          = 12,
    parameter int FB_ADDR_B        = 19
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    output logic                                          busy,
    output logic                                          frame_done,
    output logic [N_WORKERS-1:0]                          worker_activate,
    output logic [N_WORKERS*12-1:0]                       worker_start_x,
    output logic [9:0]                                    pixel_y,
    output logic [15:0]                                   pixel_y_sqrd,
    input  logic [N_WORKERS-1:0]                          worker_busy,
    input  logic [N_WORKERS*JOBS_SUBDIVISION*COLOR_B-1:0] worker_buffer,
    output logic                                          fb_we,
    output logic [FB_ADDR_B-1:0]                          fb_addr,
    output logic [COLOR_B-1:0]                            fb_data,
    input  logic                                          fb_ready
`ifdef SCHED_PERF_COUNTER_EN
    ,
    output logic [31:0]                                   frame_cycles
`endif
);

    localparam int BATCH_PIX = N_WORKERS * JOBS_SUBDIVISION;
    localparam int N_BATCH   = H_RES / BATCH_PIX;
    localparam int ROW_W     = $clog2(V_RES + 1);
    localparam int BATCH_W   = $clog2(N_BATCH + 1);
    localparam int K_W       = $clog2(JOBS_SUBDIVISION + 1);
    localparam int W_W       = $clog2(N_WORKERS + 1);

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN, RELEASE} state_t;

    state_t               state, state_n;
    logic [ROW_W-1:0]     row, row_n;
    logic [BATCH_W-1:0]   batch, batch_n;
    logic [K_W-1:0]       k, k_n;
    logic [W_W-1:0]       w, w_n;
    logic [N_WORKERS-1:0] seen;
    logic                 load, accept, last_write, enter_drain, relaunch;
    logic [COLOR_B-1:0]   sel_data;

    function automatic logic [9:0] y_of(input logic [ROW_W-1:0] r);
        return 10'(int'(r) - V_RES / 2);
    endfunction

    function automatic logic [15:0] sqrd_of(input logic signed [9:0] y);
        logic signed [19:0] p;
        p = y * y;
        return p[15:0];
    endfunction

    function automatic logic [N_WORKERS*12-1:0] start_x_of(input logic [BATCH_W-1:0] b);
        logic [N_WORKERS*12-1:0] v;
        for (int i = 0; i < N_WORKERS; i++)
            v[i*12 +: 12] = 12'(int'(b) * BATCH_PIX - H_RES / 2 + i);
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n         = state;
        load            = 1'b0;
        accept          = 1'b0;
        last_write      = 1'b0;
        enter_drain     = 1'b0;
        relaunch        = 1'b0;
        busy            = (state != IDLE);
        frame_done      = 1'b0;
        worker_activate = '0;
        fb_we           = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                worker_activate = '1;
                // A worker counts as finished only after it has been seen busy at least once.
                if (&(seen & ~worker_busy)) begin
                    enter_drain = 1'b1;
                    state_n     = DRAIN;
                end
            end
            DRAIN: begin
                worker_activate = '1;
                fb_we           = 1'b1;
                if (fb_ready) begin
                    accept = 1'b1;
                    if (w == W_W'(N_WORKERS - 1) && k == K_W'(JOBS_SUBDIVISION - 1)) begin
                        last_write = 1'b1;
                        state_n    = RELEASE;
                    end
                end
            end
            RELEASE: begin
                if (row == ROW_W'(V_RES)) begin
                    frame_done = 1'b1;
                    state_n    = IDLE;
                end else begin
                    relaunch = 1'b1;
                    state_n  = WAIT;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Next drain position and the buffer slot that becomes fb_data once it is registered.
    always_comb begin
        w_n = w;
        k_n = k;
        if (accept) begin
            if (w == W_W'(N_WORKERS - 1)) begin
                w_n = '0;
                k_n = (k == K_W'(JOBS_SUBDIVISION - 1)) ? '0 : k + K_W'(1);
            end else begin
                w_n = w + W_W'(1);
            end
        end
        if (batch == BATCH_W'(N_BATCH - 1)) begin
            batch_n = '0;
            row_n   = row + ROW_W'(1);
        end else begin
            batch_n = batch + BATCH_W'(1);
            row_n   = row;
        end
        sel_data = worker_buffer[(int'(w_n) * JOBS_SUBDIVISION + int'(k_n)) * COLOR_B +: COLOR_B];
    end

    // Drain order makes framebuffer addresses run sequentially over the whole frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            row            <= '0;
            batch          <= '0;
            k              <= '0;
            w              <= '0;
            seen           <= '0;
            pixel_y        <= '0;
            pixel_y_sqrd   <= '0;
            worker_start_x <= '0;
            fb_addr        <= '0;
            fb_data        <= '0;
        end else begin
            if (load) begin
                row            <= '0;
                batch          <= '0;
                k              <= '0;
                w              <= '0;
                seen           <= '0;
                fb_addr        <= '0;
                pixel_y        <= y_of('0);
                pixel_y_sqrd   <= sqrd_of(y_of('0));
                worker_start_x <= start_x_of('0);
            end
            if (state == WAIT) seen <= seen | worker_busy;
            if (relaunch) seen <= '0;
            if (enter_drain || accept) fb_data <= sel_data;
            if (accept) begin
                w       <= w_n;
                k       <= k_n;
                fb_addr <= fb_addr + FB_ADDR_B'(1);
            end
            if (last_write) begin
                batch          <= batch_n;
                row            <= row_n;
                pixel_y        <= y_of(row_n);
                pixel_y_sqrd   <= sqrd_of(y_of(row_n));
                worker_start_x <= start_x_of(batch_n);
            end
        end
    end

`ifdef SCHED_PERF_COUNTER_EN
    // Frozen from the frame_done cycle until the next start.
    always_ff @(posedge clk) begin
        if (rst || load)
            frame_cycles <= '0;
        else if (state != IDLE && !frame_done && frame_cycles != 32'hFFFF_FFFF)
            frame_cycles <= frame_cycles + 32'd1;
    end
`endif

endmodule
